// File: rtl/nav_msg_pkg.sv
// Shared widths, FSM state encoding and the GPS word parity function
// for the navigation-message bit source.
package nav_msg_pkg;

  localparam int WORD_BITS   = 30;
  localparam int DATA_BITS   = 24;
  localparam int PARITY_BITS = 6;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } nav_state_e;

  // Data-bit participation masks for D25..D30; bit 23 of each mask is d1.
  localparam logic [23:0] P25_MASK = 24'hEC7CD2;
  localparam logic [23:0] P26_MASK = 24'h763E69;
  localparam logic [23:0] P27_MASK = 24'hBB1F34;
  localparam logic [23:0] P28_MASK = 24'h5D8F9A;
  localparam logic [23:0] P29_MASK = 24'hAEC7CD;
  localparam logic [23:0] P30_MASK = 24'h2DEA27;

  function automatic logic [5:0] gps_parity(input logic [23:0] d,
                                            input logic        d29s,
                                            input logic        d30s);
    logic [5:0] p;
    p[5] = d29s ^ (^(d & P25_MASK));
    p[4] = d30s ^ (^(d & P26_MASK));
    p[3] = d29s ^ (^(d & P27_MASK));
    p[2] = d30s ^ (^(d & P28_MASK));
    p[1] = d30s ^ (^(d & P29_MASK));
    p[0] = d29s ^ (^(d & P30_MASK));
    return p;
  endfunction

endpackage

// File: rtl/nav_msg_gen_fifo.sv
// Data-word FIFO feeding the message serialiser; push and pop may share a
// cycle, and a push is refused whenever the registered level is full.
module nav_word_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 24,
  localparam int LW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [LW-1:0]    level,
  output logic             ready
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic [LW-1:0]    level_next_s;
  logic             ready_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign push_ok_s = push & (level_r != LW'(DEPTH));
  assign pop_ok_s  = pop & (level_r != {LW{1'b0}});
  assign pop_data  = mem_r[rd_ptr_r];
  assign level     = level_r;
  assign ready     = ready_r;

  // Next occupancy for every push/pop combination.
  always_comb begin
    level_next_s = level_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_next_s = level_r + LW'(1);
      2'b01:   level_next_s = level_r - LW'(1);
      default: level_next_s = level_r;
    endcase
  end

  // Pointers, occupancy and the registered not-full flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
      ready_r  <= 1'b1;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      level_r <= level_next_s;
      ready_r <= (level_next_s != LW'(DEPTH));
    end
  end

  // Storage array; no reset needed because the level gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/nav_msg_gen.sv
// Navigation-message bit source: FIFO-fed 30-bit GPS words sent MSB-first,
// one bit per EPOCHS_PER_BIT code epochs. `define NAV_PARITY_EN adds parity.
module nav_msg_gen
  import nav_msg_pkg::*;
#(
  parameter  int          EPOCHS_PER_BIT = 20,
  parameter  int          FIFO_DEPTH     = 4,
  parameter  logic [23:0] IDLE_WORD      = 24'h8B0000,
  localparam int          LVL_W          = $clog2(FIFO_DEPTH + 1),
  localparam int          CW             = (EPOCHS_PER_BIT > 1) ? $clog2(EPOCHS_PER_BIT) : 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             ena_in,
  input  logic             epoch_in,
  input  logic             wr_valid_in,
  input  logic [23:0]      wr_data_in,
  output logic             wr_ready_out,
  input  logic             underflow_clr_in,
  output logic             msg_out,
  output logic             bit_strobe_out,
  output logic             word_strobe_out,
  output logic             underflow_out,
  output logic [LVL_W-1:0] fifo_level_out
);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_RUN  = RUN;

  logic [0:0]           state_r;
  logic [CW-1:0]        epoch_cnt_r;
  logic [4:0]           bit_idx_r;
  logic [WORD_BITS-1:0] shift_r;
  logic                 msg_r;
  logic                 bit_strobe_r;
  logic                 word_strobe_r;
  logic                 underflow_r;

  logic                 qual_epoch_s;
  logic                 load_s;
  logic                 advance_s;
  logic                 fifo_empty_s;
  logic [DATA_BITS-1:0] fifo_data_s;
  logic [DATA_BITS-1:0] src_data_s;
  logic [LVL_W-1:0]     fifo_level_s;
  logic [WORD_BITS-1:0] enc_word_s;

  nav_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .push      (wr_valid_in),
    .push_data (wr_data_in),
    .pop       (load_s),
    .pop_data  (fifo_data_s),
    .level     (fifo_level_s),
    .ready     (wr_ready_out)
  );

  assign qual_epoch_s   = epoch_in & ena_in;
  assign fifo_empty_s   = (fifo_level_s == {LVL_W{1'b0}});
  assign src_data_s     = fifo_empty_s ? IDLE_WORD : fifo_data_s;
  assign fifo_level_out = fifo_level_s;

`ifdef NAV_PARITY_EN
  logic d29s_r;
  logic d30s_r;

  assign enc_word_s = {src_data_s ^ {DATA_BITS{d30s_r}},
                       gps_parity(src_data_s, d29s_r, d30s_r)};

  // Last two parity bits of the previous word seed the next word's parity.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      d29s_r <= 1'b0;
      d30s_r <= 1'b0;
    end else if ((state_r == ST_RUN) && !ena_in) begin
      d29s_r <= 1'b0;
      d30s_r <= 1'b0;
    end else if (load_s) begin
      d29s_r <= enc_word_s[1];
      d30s_r <= enc_word_s[0];
    end
  end
`else
  assign enc_word_s = {src_data_s, {PARITY_BITS{1'b0}}};
`endif

  // Decide whether this cycle loads a new word or moves to the next bit.
  always_comb begin
    load_s    = 1'b0;
    advance_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        load_s = qual_epoch_s;
      end
      ST_RUN: begin
        if (qual_epoch_s && (epoch_cnt_r == CW'(EPOCHS_PER_BIT - 1))) begin
          if (bit_idx_r == 5'd29) begin
            load_s = 1'b1;
          end else begin
            advance_s = 1'b1;
          end
        end else begin
          load_s    = 1'b0;
          advance_s = 1'b0;
        end
      end
      default: begin
        load_s    = 1'b0;
        advance_s = 1'b0;
      end
    endcase
  end

  // Serialiser state, bit timing and registered message outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r       <= ST_IDLE;
      epoch_cnt_r   <= {CW{1'b0}};
      bit_idx_r     <= 5'd0;
      shift_r       <= {WORD_BITS{1'b0}};
      msg_r         <= 1'b0;
      bit_strobe_r  <= 1'b0;
      word_strobe_r <= 1'b0;
    end else begin
      bit_strobe_r  <= 1'b0;
      word_strobe_r <= 1'b0;
      if ((state_r == ST_RUN) && !ena_in) begin
        state_r     <= ST_IDLE;
        epoch_cnt_r <= {CW{1'b0}};
        bit_idx_r   <= 5'd0;
        shift_r     <= {WORD_BITS{1'b0}};
        msg_r       <= 1'b0;
      end else if (load_s) begin
        state_r       <= ST_RUN;
        epoch_cnt_r   <= {CW{1'b0}};
        bit_idx_r     <= 5'd0;
        shift_r       <= enc_word_s;
        msg_r         <= enc_word_s[WORD_BITS-1];
        bit_strobe_r  <= 1'b1;
        word_strobe_r <= 1'b1;
      end else if (advance_s) begin
        epoch_cnt_r  <= {CW{1'b0}};
        bit_idx_r    <= bit_idx_r + 5'd1;
        shift_r      <= {shift_r[WORD_BITS-2:0], 1'b0};
        msg_r        <= shift_r[WORD_BITS-2];
        bit_strobe_r <= 1'b1;
      end else if ((state_r == ST_RUN) && epoch_in) begin
        epoch_cnt_r <= epoch_cnt_r + CW'(1);
      end
    end
  end

  // Sticky underflow; a new idle-word insertion beats a same-cycle clear.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      underflow_r <= 1'b0;
    end else if (load_s && fifo_empty_s) begin
      underflow_r <= 1'b1;
    end else if (underflow_clr_in) begin
      underflow_r <= 1'b0;
    end
  end

  assign msg_out         = msg_r;
  assign bit_strobe_out  = bit_strobe_r;
  assign word_strobe_out = word_strobe_r;
  assign underflow_out   = underflow_r;

endmodule

// File: tb/tb_nav_msg_gen.sv
// Self-checking bench for nav_msg_gen: fixed word table, corner sequences
// and randomized traffic against an epoch-counting reference model.
module tb_nav_msg_gen;

  localparam int          EPB    = 20;
  localparam int          DEPTH  = 4;
  localparam logic [23:0] IDLE_W = 24'h8B0000;

  // Data bits (1-based, d1 = MSB) feeding D25..D30; 0 ends a row.
  localparam int PT [6][15] = '{
    '{1, 2, 3, 5, 6, 10, 11, 12, 13, 14, 17, 18, 20, 23, 0},
    '{2, 3, 4, 6, 7, 11, 12, 13, 14, 15, 18, 19, 21, 24, 0},
    '{1, 3, 4, 5, 7, 8, 12, 13, 14, 15, 16, 19, 20, 22, 0},
    '{2, 4, 5, 6, 8, 9, 13, 14, 15, 16, 17, 20, 21, 23, 0},
    '{1, 3, 5, 6, 7, 9, 10, 14, 15, 16, 17, 18, 21, 22, 24},
    '{3, 5, 6, 8, 9, 10, 11, 13, 15, 19, 22, 23, 24, 0, 0}
  };

  logic        clk = 1'b0;
  logic        rst, ena, epoch, wv, clr;
  logic [23:0] wd;
  logic        ready, msg, bstb, wstb, uf;
  logic [2:0]  level;

  always #5 clk = ~clk;

  nav_msg_gen dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .ena_in           (ena),
    .epoch_in         (epoch),
    .wr_valid_in      (wv),
    .wr_data_in       (wd),
    .wr_ready_out     (ready),
    .underflow_clr_in (clr),
    .msg_out          (msg),
    .bit_strobe_out   (bstb),
    .word_strobe_out  (wstb),
    .underflow_out    (uf),
    .fifo_level_out   (level)
  );

  int checks = 0;
  int failures = 0;
  int ph = 0;

  // reference model state
  logic [23:0] m_q [$];
  logic        m_run, m_d29, m_d30, m_uf, m_msg, m_bstb, m_wstb;
  int          m_ep;
  logic [29:0] m_word;

  // received-stream capture
  logic [29:0] rx_q [$];
  logic [29:0] rx_sh;
  int          rx_bits, n_bstb, n_wstb;

  typedef struct {
    logic [23:0] data;
    logic [29:0] exp;
  } vec_t;
  vec_t tbl [3];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  function automatic logic [5:0] ref_parity(input logic [23:0] d, input logic s29, input logic s30);
    logic [5:0] p;
    for (int k = 0; k < 6; k++) begin
      logic acc;
      acc = (k == 0 || k == 2 || k == 5) ? s29 : s30;
      for (int j = 0; j < 15; j++)
        if (PT[k][j] != 0) acc = acc ^ d[24 - PT[k][j]];
      p[5 - k] = acc;
    end
    return p;
  endfunction

  function automatic logic [29:0] ref_encode(input logic [23:0] d, input logic s29, input logic s30);
`ifdef NAV_PARITY_EN
    return {(s30 ? ~d : d), ref_parity(d, s29, s30)};
`else
    return {d, 6'b000000};
`endif
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_run = 1'b0; m_d29 = 1'b0; m_d30 = 1'b0; m_uf = 1'b0;
    m_msg = 1'b0; m_bstb = 1'b0; m_wstb = 1'b0;
    m_ep = 0; m_word = 30'd0;
    rx_q.delete(); rx_sh = 30'd0; rx_bits = 0;
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic tick(input logic e, input logic ep, input logic v, input logic [23:0] d, input logic c);
    logic        load, uf_set, push_ok;
    logic [23:0] src;
    ena = e; epoch = ep; wv = v; wd = d; clr = c;
    push_ok = v && (m_q.size() < DEPTH);
    load = 1'b0; uf_set = 1'b0; m_bstb = 1'b0; m_wstb = 1'b0;
    if (!m_run) begin
      load = ep && e;
    end else if (!e) begin
      m_run = 1'b0; m_ep = 0; m_d29 = 1'b0; m_d30 = 1'b0;
    end else if (ep) begin
      m_ep++;
      if (m_ep == 30 * EPB) load = 1'b1;
      else if (m_ep % EPB == 0) m_bstb = 1'b1;
    end
    if (load) begin
      if (m_q.size() > 0) src = m_q.pop_front();
      else begin src = IDLE_W; uf_set = 1'b1; end
      m_word = ref_encode(src, m_d29, m_d30);
      m_d29 = m_word[1]; m_d30 = m_word[0];
      m_run = 1'b1; m_ep = 0; m_bstb = 1'b1; m_wstb = 1'b1;
    end
    if (push_ok) m_q.push_back(d);
    if (uf_set) m_uf = 1'b1;
    else if (c) m_uf = 1'b0;
    m_msg = m_run ? m_word[29 - m_ep / EPB] : 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("cycle {msg,bstb,wstb,uf,ready,level}",
        32'({msg, bstb, wstb, uf, ready, level}),
        32'({m_msg, m_bstb, m_wstb, m_uf, (m_q.size() != DEPTH), 3'(m_q.size())}));
    if (bstb) begin
      if (wstb) begin
        if (rx_bits == 30) rx_q.push_back(rx_sh);
        rx_bits = 0;
        n_wstb++;
      end
      rx_sh = {rx_sh[28:0], msg};
      rx_bits++;
      n_bstb++;
    end
    ph++;
  endtask

  task automatic run(input int n, input logic e);
    for (int i = 0; i < n; i++) tick(e, (ph % 4) == 0, 1'b0, 24'h000000, 1'b0);
  endtask

  initial begin
    int guard;
    logic c, ep;
    logic [23:0] fill [5];

    tbl[0].data = 24'h8B0000; tbl[1].data = 24'h000000; tbl[2].data = 24'hFFFFFF;
`ifdef NAV_PARITY_EN
    tbl[0].exp = 30'h22C00012; tbl[1].exp = 30'h00000029; tbl[2].exp = 30'h00000015;
`else
    tbl[0].exp = 30'h22C00000; tbl[1].exp = 30'h00000000; tbl[2].exp = 30'h3FFFFFC0;
`endif
    fill[0] = 24'h123456; fill[1] = 24'h8B0000; fill[2] = 24'hABCDEF;
    fill[3] = 24'h0F0F0F; fill[4] = 24'h555555;

    rst = 1'b1; ena = 1'b0; epoch = 1'b0; wv = 1'b0; wd = 24'h000000; clr = 1'b0;
    m_reset();
    #12;
    @(negedge clk);
    chk("reset_outputs", 32'({msg, bstb, wstb, uf, ready, level}), 32'({5'b00001, 3'd0}));
    rst = 1'b0;

    // table words through the FIFO, then an underflow word
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1, tbl[i].data, 1'b0);
    chk("level_after_push", 32'(level), 32'd3);
    n_bstb = 0; n_wstb = 0; guard = 0;
    do begin
      tick(1'b1, (ph % 4) == 0, 1'b0, 24'h000000, 1'b0);
      guard++;
    end while (!wstb && guard < 10);
    chk("first_word_strobe", 32'(wstb), 32'd1);
    run(2399, 1'b1);
    chk("bit_strobes_per_word", 32'(n_bstb), 32'd30);
    chk("word_strobes_per_word", 32'(n_wstb), 32'd1);
    guard = 0;
    while (rx_q.size() < 3 && guard < 6000) begin run(1, 1'b1); guard++; end
    chk("rx_word_count", 32'(rx_q.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < rx_q.size()) chk($sformatf("table_word%0d", i), 32'(rx_q[i]), 32'(tbl[i].exp));
    chk("underflow_set", 32'(uf), 32'd1);

    tick(1'b1, (ph % 4) == 0, 1'b0, 24'h000000, 1'b1);
    chk("underflow_cleared", 32'(uf), 32'd0);
    guard = 0;
    c = 1'b0;
    while (!c && guard < 3000) begin
      ep = (ph % 4) == 0;
      c = m_run && ep && (m_ep == 30 * EPB - 1);
      tick(1'b1, ep, 1'b0, 24'h000000, c);
      guard++;
    end
    chk("underflow_set_wins_clear", 32'(uf), 32'd1);

    // fill FIFO while idle; full refuses pushes, even on a pop cycle
    tick(1'b0, 1'b0, 1'b0, 24'h000000, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b1, fill[i], 1'b0);
    chk("full_ready", 32'(ready), 32'd0);
    chk("full_level", 32'(level), 32'd4);
    tick(1'b0, 1'b0, 1'b1, fill[4], 1'b0);
    chk("fifth_push_dropped", 32'(level), 32'd4);
    tick(1'b1, 1'b1, 1'b1, 24'h777777, 1'b0);
    chk("push_on_pop_refused", 32'(level), 32'd3);

    // drop enable mid-word, then restart cleanly
    guard = 0;
    while (!(m_run && (m_ep / EPB) == 12) && guard < 2000) begin run(1, 1'b1); guard++; end
    chk("reached_bit12", 32'(m_ep / EPB), 32'd12);
    tick(1'b0, 1'b0, 1'b0, 24'h000000, 1'b0);
    chk("disable_msg_zero", 32'(msg), 32'd0);
    rx_q.delete();
    tick(1'b1, 1'b1, 1'b0, 24'h000000, 1'b0);
    chk("reenable_word_strobe", 32'(wstb), 32'd1);
    guard = 0;
    while (rx_q.size() < 1 && guard < 3000) begin run(1, 1'b1); guard++; end
    chk("reenable_rx_count", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) chk("reenable_word_fresh_parity", 32'(rx_q[0]), 32'(tbl[0].exp));

    // randomized traffic against the model
    for (int i = 0; i < 6000; i++)
      tick($urandom_range(0, 499) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 9) == 0, 24'($urandom), $urandom_range(0, 49) == 0);

    // asynchronous reset in the middle of a word
    tick(1'b1, 1'b1, 1'b1, 24'hC0FFEE, 1'b0);
    run(40, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outputs", 32'({msg, bstb, wstb, uf, ready, level}), 32'({5'b00001, 3'd0}));
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    tick(1'b0, 1'b0, 1'b1, 24'h000000, 1'b0);
    run(200, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nav_msg_gen.md
Name: nav_msg_gen

Overview:
Navigation-message bit source that drives the message input of the GPS generator core. Software pushes 24-bit data words through a small FIFO. Each word gets 6 GPS parity bits (IS-GPS-200) and is serialised MSB-first at 50 bps, one bit per EPOCHS_PER_BIT C/A code epochs. Epoch timing comes from the core's code-start pulse, so message bit edges stay aligned to code epochs.

Parameters:
EPOCHS_PER_BIT, 20, C/A epochs per message bit
FIFO_DEPTH, 4, data-word FIFO depth; power of two, >=2
IDLE_WORD, 24'h8B0000, data sent when the FIFO is empty at a word boundary

Ports:
clk_in  in  1  system clock
rst_in  in  1  reset, asynchronous, active-high
ena_in  in  1  generator enable (from register bank)
epoch_in  in  1  single-cycle C/A epoch pulse (core start_out)
wr_valid_in  in  1  push request
wr_data_in  in  24  data bits d1..d24, d1 = bit 23
wr_ready_out  out  1  FIFO not full
underflow_clr_in  in  1  clears underflow_out
msg_out  out  1  current message bit to core msg_in
bit_strobe_out  out  1  one-cycle pulse when msg_out takes a new bit
word_strobe_out  out  1  one-cycle pulse when a new word starts
underflow_out  out  1  sticky: idle word was inserted
fifo_level_out  out  $clog2(FIFO_DEPTH+1)  words held

Behaviour:
- Reset: all outputs 0 except wr_ready_out=1. FIFO empty, epoch_cnt=0, bit_idx=0, shift reg=0, D29*=D30*=0, state IDLE.
- Push: accepted when wr_valid_in & wr_ready_out. wr_ready_out=(level!=FIFO_DEPTH), from registered level. When full, a push is refused even if a pop happens in the same cycle.
- FSM IDLE:
  - msg_out=0.
  - On epoch_in & ena_in: load word, bit_idx=0, epoch_cnt=0, go RUN.
  - Pulse bit_strobe_out and word_strobe_out the next cycle.
- FSM RUN, on epoch_in:
  - If epoch_cnt==EPOCHS_PER_BIT-1: epoch_cnt=0 and advance bit; otherwise epoch_cnt++.
  - Advance bit when bit_idx<29: shift left, bit_idx++, bit_strobe_out.
  - Advance bit when bit_idx==29: load next word, bit_idx=0, bit_strobe_out and word_strobe_out.
- msg_out = shift-reg bit 29, registered. It changes exactly 1 cycle after the qualifying epoch_in.
- Word load:
  - Pop FIFO if non-empty; else use IDLE_WORD and set underflow_out.
  - With push and load in the same cycle while the FIFO is empty, the load takes IDLE_WORD and the pushed word is stored.
  - Level is updated for both operations in that cycle.
- Encoding: complement d1..d24 if D30*=1. Compute D25..D30 per IS-GPS-200 Table 20-XIV from the uncomplemented d and D29*/D30*. Shift reg = {d', D25..D30}. D29*/D30* take D29/D30 of the loaded word.
- ena_in low in RUN: go IDLE next cycle, msg_out=0, D29*=D30*=0, counters 0. FIFO contents are kept; the partly sent word is lost.
- underflow_out: sticky. Cleared by underflow_clr_in. If clear and set occur in the same cycle, set wins.
- epoch_in is ignored in IDLE while ena_in=0.

Optional Feature:
NAV_PARITY_EN.
- Defined: parity and complementing as above.
- Undefined: loaded word = {d1..d24, 6'b0}; no complementing; D29*/D30* registers are removed.

Decomposition:
- Package nav_msg_pkg holds:
  - WORD_BITS=30, DATA_BITS=24, PARITY_BITS=6
  - FSM state enum {IDLE, RUN}
  - function gps_parity(d[23:0], d29s, d30s) returning 6 bits
- Sub-module nav_word_fifo: synchronous FIFO, DEPTH x 24, level output, simultaneous push/pop.

Test Plan:
- Reset mid-RUN -> all outputs 0 the same cycle (asynchronous); wr_ready_out=1; fifo_level_out=0.
- Push 24'h8B0000, enable, epoch every 4 clk -> 30-bit word 0x22C00012 sent MSB-first; each bit held 20 epochs; bit_strobe_out 30 times; word_strobe_out once.
- Next word 24'h000000 (D29*=1, D30*=0) -> 0x00000029. A third word 24'hFFFFFF then goes out with data complemented, because D30*=1.
- FIFO empty at a word boundary -> IDLE_WORD sent; underflow_out=1 until underflow_clr_in; simultaneous clear and set -> stays 1.
- Push 4 words -> wr_ready_out=0; 5th push with wr_valid_in is dropped; push on a pop cycle while full is refused; level stays 4→3.
- ena_in dropped at bit 12 -> msg_out=0 next cycle; re-enable -> new word starts at bit 0 with D29*=D30*=0.
- Without NAV_PARITY_EN -> 24'h8B0000 transmits as 0x22C00000; no complementing.
